cc_capture: RTL

Registered capture stage directly downstream of the `cc` combinational block. It samples the 20-bit `cc` output vector on qualified cycles and can optionally keep only samples that differ from the previous qualified sample. Accepted samples are buffered in a small FIFO and drained over a valid/ready handshake to the next consumer. Overflow losses are counted so the bench and system can detect dropped vectors.

---
 rtl/cc_pkg.sv | 33 +++
 rtl/cc_capture_if.sv | 36 +++
 rtl/cc_fifo.sv | 87 ++++++++
 rtl/cc_capture.sv | 92 +++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// cc_pkg: shared definitions for the cc capture path.
//   CC_OUT_W      width of the packed cc output vector
//   CC_W..CC_P0   bit positions of each cc output inside the vector
//   cc_vec_t      packed vector type carried through the capture FIFO
package cc_pkg;

   localparam int CC_OUT_W = 20;

   // Bit positions inside the packed vector, LSB first.
   localparam int CC_W  = 0;
   localparam int CC_XX = 1;
   localparam int CC_Y  = 2;
   localparam int CC_Z  = 3;
   localparam int CC_A0 = 4;
   localparam int CC_B0 = 5;
   localparam int CC_C0 = 6;
   localparam int CC_D0 = 7;
   localparam int CC_E0 = 8;
   localparam int CC_F0 = 9;
   localparam int CC_G0 = 10;
   localparam int CC_H0 = 11;
   localparam int CC_I0 = 12;
   localparam int CC_J0 = 13;
   localparam int CC_K0 = 14;
   localparam int CC_L0 = 15;
   localparam int CC_M0 = 16;
   localparam int CC_N0 = 17;
   localparam int CC_O0 = 18;
   localparam int CC_P0 = 19;

   typedef logic [CC_OUT_W-1:0] cc_vec_t;

endpackage

// File: rtl/cc_capture_if.sv
// cc_capture_if: bundles the sample input, the drain handshake and the
// status outputs of cc_capture.
//   in_vec/in_valid/chg_only   sample source side
//   out_vec/out_valid/out_ready drain handshake
//   count/full/empty/drop_cnt  occupancy and loss status
// Modports: slave = cc_capture, master = producer/consumer around it.
interface cc_capture_if #(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
);
   import cc_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);

   cc_vec_t            in_vec;
   logic               in_valid;
   logic               chg_only;
   cc_vec_t            out_vec;
   logic               out_valid;
   logic               out_ready;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               empty;
   logic [DROP_W-1:0]  drop_cnt;

   modport slave (
      input  in_vec, in_valid, chg_only, out_ready,
      output out_vec, out_valid, count, full, empty, drop_cnt
   );

   modport master (
      output in_vec, in_valid, chg_only, out_ready,
      input  out_vec, out_valid, count, full, empty, drop_cnt
   );

endinterface

// File: rtl/cc_fifo.sv
// cc_fifo: generic synchronous FIFO, register storage with the head word
// read straight from the entry addressed by the read pointer.
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write one word (caller guarantees !full || pop)
//   pop             retire the head word (caller guarantees !empty)
//   head            current head word
//   count/full/empty occupancy, decoded from registered state only
// DEPTH must be a power of two so the pointers wrap naturally.
module cc_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // One register per entry; only the entry under the write pointer loads.
   // A push while full with a pop writes the slot being retired this cycle,
   // which is safe because the head was already presented before the edge.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      logic [WIDTH-1:0] mem_d;
      always_comb begin
         mem_d = mem_q[gi];
         if (push && (wr_ptr_q == PTR_W'(gi))) begin
            mem_d = push_data;
         end
      end
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mem_q[gi] <= '0;
         end else begin
            mem_q[gi] <= mem_d;
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

endmodule

// File: rtl/cc_capture.sv
// cc_capture: registered capture stage behind the cc combinational block.
// Samples in_vec on in_valid cycles, optionally keeps only samples that
// differ from the previous qualified one, buffers them in cc_fifo and
// counts samples lost to overflow with a saturating counter.
//   clk, rst  clock, asynchronous active-high reset
//   bus       cc_capture_if.slave: sample input, drain handshake, status
module cc_capture
   import cc_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   cc_capture_if.slave  bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   cc_vec_t           last_vec_q, last_vec_d;
   logic              first_q, first_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   logic             candidate;
   logic             push;
   logic             pop;
   logic             drop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   cc_vec_t          fifo_head;

   // Push/drop arbitration. out_ready only reaches push through pop, so a
   // full FIFO can still accept a sample on a cycle it is being drained.
   always_comb begin
      candidate = bus.in_valid &&
                  (!bus.chg_only || first_q || (bus.in_vec != last_vec_q));
      pop       = !fifo_empty && bus.out_ready;
      push      = candidate && (!fifo_full || pop);
      drop      = candidate && fifo_full && !pop;
   end

   // Change tracking follows every qualified sample, enqueued or not, so
   // switching chg_only mid-stream compares against the true previous one.
   always_comb begin
      last_vec_d = last_vec_q;
      first_d    = first_q;
      drop_cnt_d = drop_cnt_q;
      if (bus.in_valid) begin
         last_vec_d = bus.in_vec;
         first_d    = 1'b0;
      end
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_vec_q <= '0;
         first_q    <= 1'b1;
         drop_cnt_q <= '0;
      end else begin
         last_vec_q <= last_vec_d;
         first_q    <= first_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   cc_fifo #(
      .WIDTH (CC_OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bus.in_vec),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.out_vec   = fifo_head;
   assign bus.out_valid = !fifo_empty;
   assign bus.count     = fifo_count;
   assign bus.full      = fifo_full;
   assign bus.empty     = fifo_empty;
   assign bus.drop_cnt  = drop_cnt_q;

endmodule
